// File: rtl/hbridge_gate_driver.sv
// rtl/hbridge_gate_driver.sv - H-bridge gate driver with dead-time insertion and high-side PWM
//
// Purpose: turns a 2-bit direction command into the four H-bridge gate
// signals. Every direction change, including drive-to-stop, passes through a
// DEAD state with all gates off. The high-side switch of the active leg is
// PWM-modulated.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   dir_cmd  in   00 stop, 01 clockwise, 10 counter-clockwise, 11 illegal (acts as stop)
//   duty     in   high-side on-cycles per PWM period, applied at the next period start
//   hs_a     out  leg A high-side gate
//   ls_a     out  leg A low-side gate
//   hs_b     out  leg B high-side gate
//   ls_b     out  leg B low-side gate
//   state_o  out  00 OFF, 01 DRIVE_CW, 10 DRIVE_CCW, 11 DEAD
//   cmd_err  out  one-cycle pulse for each edge that sampled dir_cmd==11
module hbridge_gate_driver #(
    parameter int DEAD_CYCLES = 8,
    parameter int PWM_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          dir_cmd,
    input  logic [PWM_BITS-1:0] duty,
    output logic                hs_a,
    output logic                ls_a,
    output logic                hs_b,
    output logic                ls_b,
    output logic [1:0]          state_o,
    output logic                cmd_err
);

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_CW   = 2'b01;
    localparam logic [1:0] ST_CCW  = 2'b10;
    localparam logic [1:0] ST_DEAD = 2'b11;

    localparam int                  CNT_W     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};

    logic [1:0]          r_state;
    logic [1:0]          r_target;
    logic [CNT_W-1:0]    r_dead_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty_q;
    logic                r_cmd_err;

    logic [1:0]          w_cmd_state;
    logic                w_pwm_on;

    // Illegal 11 collapses onto OFF so it behaves exactly like a stop.
    always_comb begin
        w_cmd_state = ST_OFF;
        case (dir_cmd)
            2'b01:   w_cmd_state = ST_CW;
            2'b10:   w_cmd_state = ST_CCW;
            default: w_cmd_state = ST_OFF;
        endcase
    end

    assign w_pwm_on = (r_pwm_cnt < r_duty_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_target   <= ST_OFF;
            r_dead_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_duty_q   <= '0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            // Latch duty only at the period boundary so a period never mixes two duties.
            if (r_pwm_cnt == PWM_MAX) begin
                r_duty_q <= duty;
            end
            r_cmd_err <= (dir_cmd == 2'b11);

            case (r_state)
                ST_DEAD: begin
                    // A changed request restarts the full dead-time, even if the
                    // new target is OFF.
                    if (w_cmd_state != r_target) begin
                        r_target   <= w_cmd_state;
                        r_dead_cnt <= DEAD_LOAD;
                    end else if (r_dead_cnt == '0) begin
                        r_state <= r_target;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - 1'b1;
                    end
                end
                default: begin
                    // OFF, DRIVE_CW, DRIVE_CCW: any change of requested state
                    // (drive-to-stop included) goes through DEAD first.
                    if (w_cmd_state != r_state) begin
                        r_state    <= ST_DEAD;
                        r_target   <= w_cmd_state;
                        r_dead_cnt <= DEAD_LOAD;
                    end
                end
            endcase
        end
    end

    // Gates depend only on registered state, so no input glitch reaches them.
    always_comb begin
        hs_a = 1'b0;
        ls_a = 1'b0;
        hs_b = 1'b0;
        ls_b = 1'b0;
        case (r_state)
            ST_CW: begin
                hs_a = w_pwm_on;
                ls_b = 1'b1;
            end
            ST_CCW: begin
                hs_b = w_pwm_on;
                ls_a = 1'b1;
            end
            default: begin
                hs_a = 1'b0;
                ls_a = 1'b0;
                hs_b = 1'b0;
                ls_b = 1'b0;
            end
        endcase
    end

    assign state_o = r_state;
    assign cmd_err = r_cmd_err;

endmodule
